tlul_sram_slave: RTL

- Parametrised TL-UL slave endpoint with byte-maskable SRAM backing and configurable response latency.
- Accepts multiple outstanding requests and checks address range, opcode, size and alignment, answering illegal requests with d_error.
- Sits on the slave socket of tlul_interconnect_top and replaces the fixed single-response behavioural slave used in simulation.
- Responses return in request order.

---
 rtl/tlul_pkg.sv | 29 ++
 rtl/tlul_sram_slave_if.sv | 41 ++++
 rtl/tlul_resp_fifo.sv | 50 +++++
 rtl/tlul_sram_slave.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants and the response record carried through the
// slave's latency pipeline and response FIFO.
package tlul_pkg;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Record fields are sized for the widest supported configuration
    // (64-bit data, up to 8-bit source, 3-bit opcode/param/size); narrower
    // instances zero-extend on entry and slice on exit.
    localparam int RSP_OP_W   = 3;
    localparam int RSP_PRM_W  = 3;
    localparam int RSP_SZ_W   = 3;
    localparam int RSP_SRC_W  = 8;
    localparam int RSP_DATA_W = 64;

    typedef struct packed {
        logic [RSP_OP_W-1:0]   opcode;
        logic [RSP_PRM_W-1:0]  param;
        logic [RSP_SZ_W-1:0]   size;
        logic [RSP_SRC_W-1:0]  source;
        logic [RSP_DATA_W-1:0] data;
        logic                  error;
    } resp_t;

endpackage

// File: rtl/tlul_sram_slave_if.sv
// TL-UL A/D channel bundle between a master and the SRAM slave.
interface tlul_sram_slave_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3
);
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SRC_WIDTH-1:0]    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SRC_WIDTH-1:0]    d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
    );
endinterface

// File: rtl/tlul_resp_fifo.sv
// Synchronous FIFO with registered storage; head word is visible on rdata.
module tlul_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage rounds up to a power of two so pointers wrap naturally.
    logic [WIDTH-1:0] mem [2**PW];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage needs no reset; empty gates its visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL slave endpoint: byte-maskable SRAM, legality checks at accept,
// fixed-latency response pipeline feeding an in-order response FIFO.
module tlul_sram_slave
    import tlul_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 2,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    MEM_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE   = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK   = 32'hFFFF_F000,
    parameter int                    LATENCY      = 2,
    parameter int                    OUTSTANDING  = 4,
    parameter logic [SINK_WIDTH-1:0] SINK_ID      = '0
) (
    input  logic                          clk_100,
    input  logic                          reset_n,
    tlul_sram_slave_if.slave              bus,
    output logic [$clog2(OUTSTANDING):0]  inflight
);
    localparam int LM = $clog2(MASK_WIDTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(OUTSTANDING) + 1;

    logic                  a_ready, a_fire, d_valid, d_fire;
    logic                  hit, op_ok, size_ok, align_ok, legal, is_get;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    resp_t                 a_rsp, head;
    resp_t                 pipe [LATENCY];
    logic [LATENCY-1:0]    vld_pipe;
    logic                  fifo_full, fifo_empty;
    logic                  unused_bits;

    // Held low through reset; inflight alone bounds acceptance afterwards.
    assign a_ready     = reset_n && (inflight < CW'(OUTSTANDING));
    assign a_fire      = bus.a_valid && a_ready;
    assign bus.a_ready = a_ready;

    assign idx     = bus.a_address[LM +: IW];
    assign hit     = ((bus.a_address & SLAVE_MASK) == SLAVE_BASE);
    assign is_get  = (bus.a_opcode == OPCODE_WIDTH'(OP_GET));
    assign op_ok   = is_get || (bus.a_opcode == OPCODE_WIDTH'(OP_PUT_FULL))
                            || (bus.a_opcode == OPCODE_WIDTH'(OP_PUT_PARTIAL));
    assign size_ok = (bus.a_size <= SIZE_WIDTH'(LM));
    assign legal   = hit && op_ok && size_ok && align_ok;

    // Address bits below the transfer size must be zero.
    always_comb begin
        align_ok = 1'b1;
        for (int i = 0; i < LM; i++)
            if (i < int'(bus.a_size) && bus.a_address[i]) align_ok = 1'b0;
    end

    // Build the response at accept; Get data is sampled from the array now.
    always_comb begin
        a_rsp        = '0;
        a_rsp.opcode = is_get ? OP_ACK_DATA : OP_ACK;
        a_rsp.param  = RSP_PRM_W'(bus.a_param);
        a_rsp.size   = RSP_SZ_W'(bus.a_size);
        a_rsp.source = RSP_SRC_W'(bus.a_source);
        a_rsp.error  = !legal;
        a_rsp.data   = (legal && is_get) ? RSP_DATA_W'(mem[idx]) : '0;
    end

    // Byte-masked SRAM write on the accept edge of a legal Put.
    always_ff @(posedge clk_100) begin
        if (a_fire && legal && !is_get)
            for (int b = 0; b < MASK_WIDTH; b++)
                if (bus.a_mask[b]) mem[idx][8*b +: 8] <= bus.a_data[8*b +: 8];
    end

    // Fixed-latency shift pipeline in front of the response FIFO.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= a_fire;
            pipe[0]     <= a_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pipe[i]     <= pipe[i-1];
            end
        end
    end

    // inflight caps the total held in pipe+FIFO, so full never blocks a push.
    tlul_resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (OUTSTANDING)
    ) u_resp_fifo (
        .clk   (clk_100),
        .rst_n (reset_n),
        .push  (vld_pipe[LATENCY-1]),
        .wdata (pipe[LATENCY-1]),
        .pop   (d_fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Accepted-but-unretired count.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({a_fire, d_fire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    // D fields read as zero whenever no response is presented.
    assign d_valid      = !fifo_empty;
    assign d_fire       = d_valid && bus.d_ready;
    assign bus.d_valid  = d_valid;
    assign bus.d_opcode = d_valid ? head.opcode[OPCODE_WIDTH-1:0] : '0;
    assign bus.d_param  = d_valid ? head.param[PARAM_WIDTH-1:0]   : '0;
    assign bus.d_size   = d_valid ? head.size[SIZE_WIDTH-1:0]     : '0;
    assign bus.d_source = d_valid ? head.source[SRC_WIDTH-1:0]    : '0;
    assign bus.d_data   = d_valid ? head.data[DATA_WIDTH-1:0]     : '0;
    assign bus.d_error  = d_valid && head.error;
    assign bus.d_sink   = d_valid ? SINK_ID : '0;

    // Record bits beyond this instance's widths are intentionally dropped.
    assign unused_bits = ^{head, fifo_full};
endmodule
